fnd_digit_scanner: RTL and testbench

//   Parametrised multi-digit FND (7-segment) scan counter. It steps a digit index on each scan strobe and skips

---
 rtl/fnd_pkg.sv | 33 +++
 rtl/fnd_next_idx.sv | 43 ++++
 rtl/fnd_digit_scanner.sv | 118 +++++++++++
 tb/tb_fnd_digit_scanner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared FND scan constants and helper functions
package fnd_pkg;

    localparam int   FND_MAX_DIGITS = 16;

    // Logical select levels; the scanner applies output polarity on top of these.
    localparam logic FND_SEL_ON  = 1'b1;
    localparam logic FND_SEL_OFF = 1'b0;

    // Bits needed to index n digits, never less than 1.
    function automatic int fnd_clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) begin
                r = k + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    function automatic logic [FND_MAX_DIGITS-1:0] fnd_onehot(input int idx, input int n);
        logic [FND_MAX_DIGITS-1:0] r;
        for (int k = 0; k < FND_MAX_DIGITS; k++) begin
            r[k] = (k == idx) && (k < n);
        end
        return r;
    endfunction

endpackage

// File: rtl/fnd_next_idx.sv
// rtl/fnd_next_idx.sv - rotate-priority finder: first enabled digit after idx, circular
module fnd_next_idx import fnd_pkg::*; #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = fnd_clog2(DIGITS)
) (
    input  logic [CNT_W-1:0]  idx_i,
    input  logic [DIGITS-1:0] mask_i,
    output logic [CNT_W-1:0]  next_idx_o,
    output logic              found_o,
    output logic              wrapped_o
);

    int               cur;
    int               cand;
    logic [CNT_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        next_idx_o = idx_i;
        found      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        cur        = int'(idx_i);
        // An out-of-range index restarts the search from digit 0.
        if (cur >= DIGITS) begin
            cur = DIGITS - 1;
        end
        for (int k = 1; k <= DIGITS; k++) begin
            cand = cur + k;
            if (cand >= DIGITS) begin
                cand = cand - DIGITS;
            end
            cand_idx = CNT_W'(cand);
            if (!found && mask_i[cand_idx]) begin
                found      = 1'b1;
                next_idx_o = cand_idx;
            end
        end
        found_o   = found;
        wrapped_o = found && (next_idx_o <= idx_i);
    end

endmodule

// File: rtl/fnd_digit_scanner.sv
// rtl/fnd_digit_scanner.sv - masked FND digit scan counter with one-hot select and frame tick
// Optional post-advance blanking is enabled by defining FND_BLANK_EN.
module fnd_digit_scanner import fnd_pkg::*; #(
    parameter int  DIGITS     = 4,
    parameter bit  ACTIVE_LOW = 1'b1,
    parameter int  BLANK_CYC  = 2,
    localparam int CNT_W      = fnd_clog2(DIGITS)
) (
    input  logic              i_clk_fnd,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic [DIGITS-1:0] i_digit_mask,
    output logic [CNT_W-1:0]  o_counter_fnd,
    output logic [DIGITS-1:0] o_digit_sel,
    output logic              o_frame_tick,
    output logic              o_blank
);

    localparam logic [DIGITS-1:0] SEL_POL  = {DIGITS{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_IDLE = {DIGITS{FND_SEL_OFF}} ^ SEL_POL;

    if (DIGITS < 2 || DIGITS > FND_MAX_DIGITS) begin : g_bad_digits
        $error("fnd_digit_scanner: DIGITS out of range");
    end
    if (BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_bad_blank
        $error("fnd_digit_scanner: BLANK_CYC out of range");
    end

    logic [CNT_W-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0]         sel_q, sel_d;
    logic                      tick_q, tick_d;
    logic [CNT_W-1:0]          nxt_idx;
    logic                      nxt_found;
    logic                      nxt_wrapped;
    logic                      advance;
    logic [DIGITS-1:0]         sel_on;
    logic [FND_MAX_DIGITS-1:0] oh_full;
    logic                      unused_oh;

    assign unused_oh = ^oh_full;

    fnd_next_idx #(
        .DIGITS (DIGITS),
        .CNT_W  (CNT_W)
    ) u_next_idx (
        .idx_i      (idx_q),
        .mask_i     (i_digit_mask),
        .next_idx_o (nxt_idx),
        .found_o    (nxt_found),
        .wrapped_o  (nxt_wrapped)
    );

`ifdef FND_BLANK_EN
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYC);

    logic [7:0] blank_cnt_q, blank_cnt_d;
    logic       blank_active;

    assign blank_active = (blank_cnt_q != 8'd0);
    assign o_blank      = blank_active;

    always_ff @(posedge i_clk_fnd or posedge i_reset) begin
        if (i_reset) begin
            blank_cnt_q <= 8'd0;
        end else begin
            blank_cnt_q <= blank_cnt_d;
        end
    end
`else
    assign o_blank = 1'b0;
`endif

    always_comb begin
        oh_full = fnd_onehot(int'(idx_q), DIGITS);
        advance = i_en & nxt_found;
`ifdef FND_BLANK_EN
        // Strobes arriving while dark are dropped, not queued.
        advance     = advance & ~blank_active;
        blank_cnt_d = blank_cnt_q;
        if (advance) begin
            blank_cnt_d = BLANK_LOAD;
        end else if (blank_active) begin
            blank_cnt_d = blank_cnt_q - 8'd1;
        end
`endif
        idx_d  = advance ? nxt_idx : idx_q;
        tick_d = advance & nxt_wrapped;

        // Select follows the registered index, so it trails o_counter_fnd by one cycle.
        sel_on = {DIGITS{FND_SEL_OFF}};
        for (int k = 0; k < DIGITS; k++) begin
            sel_on[k] = (oh_full[k] & i_digit_mask[k]) ? FND_SEL_ON : FND_SEL_OFF;
        end
`ifdef FND_BLANK_EN
        if (blank_cnt_d != 8'd0) begin
            sel_on = {DIGITS{FND_SEL_OFF}};
        end
`endif
        sel_d = sel_on ^ SEL_POL;
    end

    always_ff @(posedge i_clk_fnd or posedge i_reset) begin
        if (i_reset) begin
            idx_q  <= '0;
            sel_q  <= SEL_IDLE;
            tick_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            tick_q <= tick_d;
        end
    end

    assign o_counter_fnd = idx_q;
    assign o_digit_sel   = sel_q;
    assign o_frame_tick  = tick_q;

endmodule

// File: tb/tb_fnd_digit_scanner.sv
// tb/tb_fnd_digit_scanner.sv - self-checking bench for fnd_digit_scanner (4- and 6-digit instances)
module tb_fnd_digit_scanner;

`ifdef FND_BLANK_EN
    localparam int TB_BLANK = 3;
    localparam int MB       = 3;
`else
    localparam int TB_BLANK = 2;
    localparam int MB       = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en, en6;
    logic [3:0] mask;
    logic [5:0] mask6;
    logic [1:0] idx;
    logic [3:0] sel;
    logic       tick, blank;
    logic [2:0] idx6;
    logic [5:0] sel6;
    logic       tick6, blank6;

    int total = 0;
    int bad   = 0;

    // Reference state for the 4-digit instance
    int         m_idx;
    int         m_blank;
    logic [3:0] m_sel;
    logic       m_tick;

    always #5 clk = ~clk;

    fnd_digit_scanner #(.DIGITS(4), .ACTIVE_LOW(1'b1), .BLANK_CYC(TB_BLANK)) dut (
        .i_clk_fnd     (clk),
        .i_reset       (rst),
        .i_en          (en),
        .i_digit_mask  (mask),
        .o_counter_fnd (idx),
        .o_digit_sel   (sel),
        .o_frame_tick  (tick),
        .o_blank       (blank)
    );

    fnd_digit_scanner #(.DIGITS(6), .ACTIVE_LOW(1'b1), .BLANK_CYC(TB_BLANK)) dut6 (
        .i_clk_fnd     (clk),
        .i_reset       (rst),
        .i_en          (en6),
        .i_digit_mask  (mask6),
        .o_counter_fnd (idx6),
        .o_digit_sel   (sel6),
        .o_frame_tick  (tick6),
        .o_blank       (blank6)
    );

    // Smallest enabled digit above cur, else smallest enabled digit overall; -1 if none.
    function automatic int next_en(input int cur, input logic [3:0] mk);
        int r;
        r = -1;
        for (int j = 3; j >= 0; j--) if (mk[j] && j > cur) r = j;
        if (r < 0) begin
            for (int j = 3; j >= 0; j--) if (mk[j]) r = j;
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_idx   = 0;
        m_blank = 0;
        m_sel   = 4'hF;
        m_tick  = 1'b0;
    endfunction

    function automatic void model_edge(input logic e, input logic [3:0] mk);
        int         nx;
        bit         adv;
        logic [3:0] oh;
        nx     = next_en(m_idx, mk);
        adv    = e && (nx >= 0) && (m_blank == 0);
        oh     = 4'b0001 << m_idx;
        m_tick = adv && (nx <= m_idx);
        if (adv) m_blank = MB;
        else if (m_blank > 0) m_blank--;
        m_sel = (m_blank > 0) ? 4'hF : ~(mk & oh);
        if (adv) m_idx = nx;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic e, input logic [3:0] mk);
        en   = e;
        mask = mk;
        @(posedge clk);
        model_edge(e, mk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        en6 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (idx !== 2'd0)    begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx); end
        total++; if (sel !== 4'hF)    begin bad++; $display("FAIL reset_sel got=%b exp=1111", sel); end
        total++; if (tick !== 1'b0)   begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        total++; if (blank !== 1'b0)  begin bad++; $display("FAIL reset_blank got=%b exp=0", blank); end
        total++; if (idx6 !== 3'd0)   begin bad++; $display("FAIL reset_idx6 got=%0d exp=0", idx6); end
        total++; if (sel6 !== 6'h3F)  begin bad++; $display("FAIL reset_sel6 got=%b exp=111111", sel6); end
        total++; if (blank6 !== 1'b0) begin bad++; $display("FAIL reset_blank6 got=%b exp=0", blank6); end
    endtask

    task automatic test_full_scan();
        int ticks;
        logic [3:0] exp_sel;
        do_reset();
        cyc(1'b0, 4'hF);
        total++; if (sel !== 4'b1110) begin bad++; $display("FAIL scan_first_sel got=%b exp=1110", sel); end
        ticks = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 4'hF);
            if (tick === 1'b1) ticks++;
            total++; if (idx !== 2'(k % 4)) begin bad++; $display("FAIL scan_idx k=%0d got=%0d exp=%0d", k, idx, k % 4); end
            total++; if (tick !== (k % 4 == 0)) begin bad++; $display("FAIL scan_tick k=%0d got=%b exp=%b", k, tick, (k % 4 == 0)); end
            repeat (MB + 1) cyc(1'b0, 4'hF);
            exp_sel = ~(4'b0001 << (k % 4));
            total++; if (sel !== exp_sel) begin bad++; $display("FAIL scan_sel k=%0d got=%b exp=%b", k, sel, exp_sel); end
        end
        total++; if (ticks != 2) begin bad++; $display("FAIL scan_tick_count got=%0d exp=2", ticks); end
    endtask

    task automatic test_six_digit();
        do_reset();
        mask6 = 6'h3F;
        for (int k = 1; k <= 14; k++) begin
            en6 = 1'b1;
            cyc(1'b0, 4'hF);
            en6 = 1'b0;
            total++; if (idx6 !== 3'(k % 6)) begin bad++; $display("FAIL six_idx k=%0d got=%0d exp=%0d", k, idx6, k % 6); end
            total++; if (tick6 !== (k % 6 == 0)) begin bad++; $display("FAIL six_tick k=%0d got=%b exp=%b", k, tick6, (k % 6 == 0)); end
            repeat (MB) cyc(1'b0, 4'hF);
        end
    endtask

    task automatic test_sparse_mask();
        int exp_i;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 4'b1010);
            exp_i = (k % 2 == 0) ? 1 : 3;
            total++; if (idx !== 2'(exp_i)) begin bad++; $display("FAIL sparse_idx k=%0d got=%0d exp=%0d", k, idx, exp_i); end
            total++; if (tick !== (k > 0 && k % 2 == 0)) begin bad++; $display("FAIL sparse_tick k=%0d got=%b exp=%b", k, tick, (k > 0 && k % 2 == 0)); end
            total++; if (sel[0] !== 1'b1 || sel[2] !== 1'b1) begin bad++; $display("FAIL sparse_sel k=%0d got=%b exp=1x1x", k, sel); end
            repeat (MB) cyc(1'b0, 4'b1010);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 4'b0100);
            total++; if (idx !== 2'd2) begin bad++; $display("FAIL single_idx k=%0d got=%0d exp=2", k, idx); end
            total++; if (tick !== 1'b1) begin bad++; $display("FAIL single_tick k=%0d got=%b exp=1", k, tick); end
            repeat (MB) cyc(1'b0, 4'b0100);
        end
    endtask

    task automatic test_zero_mask();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 4'b0000);
            total++; if (idx !== 2'd0) begin bad++; $display("FAIL zero_idx k=%0d got=%0d exp=0", k, idx); end
            total++; if (sel !== 4'hF) begin bad++; $display("FAIL zero_sel k=%0d got=%b exp=1111", k, sel); end
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL zero_tick k=%0d got=%b exp=0", k, tick); end
        end
        cyc(1'b0, 4'b0001);
        total++; if (sel !== 4'b1110) begin bad++; $display("FAIL zero_restore_sel got=%b exp=1110", sel); end
    endtask

    task automatic test_mask_current();
        do_reset();
        cyc(1'b1, 4'hF);
        repeat (MB + 1) cyc(1'b0, 4'hF);
        total++; if (sel !== 4'b1101) begin bad++; $display("FAIL maskcur_pre_sel got=%b exp=1101", sel); end
        cyc(1'b0, 4'b1101);
        total++; if (sel !== 4'hF) begin bad++; $display("FAIL maskcur_sel got=%b exp=1111", sel); end
        total++; if (idx !== 2'd1) begin bad++; $display("FAIL maskcur_idx got=%0d exp=1", idx); end
        cyc(1'b1, 4'b1101);
        total++; if (idx !== 2'd2) begin bad++; $display("FAIL maskcur_next_idx got=%0d exp=2", idx); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 4'hF);
            repeat (MB + 1) cyc(1'b0, 4'hF);
        end
        total++; if (idx !== 2'd2) begin bad++; $display("FAIL areset_pre_idx got=%0d exp=2", idx); end
        en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        total++; if (idx !== 2'd0)   begin bad++; $display("FAIL areset_idx got=%0d exp=0", idx); end
        total++; if (sel !== 4'hF)   begin bad++; $display("FAIL areset_sel got=%b exp=1111", sel); end
        total++; if (tick !== 1'b0)  begin bad++; $display("FAIL areset_tick got=%b exp=0", tick); end
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL areset_blank got=%b exp=0", blank); end
        @(negedge clk);
        total++; if (tick !== 1'b0)  begin bad++; $display("FAIL areset_hold_tick got=%b exp=0", tick); end
        rst = 1'b0;
        model_reset();
        cyc(1'b1, 4'hF);
        total++; if (idx !== 2'd1) begin bad++; $display("FAIL areset_after_idx got=%0d exp=1", idx); end
    endtask

    task automatic test_blank();
        do_reset();
        cyc(1'b0, 4'hF);
`ifdef FND_BLANK_EN
        cyc(1'b1, 4'hF);
        total++; if (idx !== 2'd1 || blank !== 1'b1 || sel !== 4'hF) begin bad++; $display("FAIL blank_start idx=%0d blank=%b sel=%b exp idx=1 blank=1 sel=1111", idx, blank, sel); end
        cyc(1'b1, 4'hF);
        total++; if (idx !== 2'd1 || blank !== 1'b1 || sel !== 4'hF) begin bad++; $display("FAIL blank_drop idx=%0d blank=%b sel=%b exp idx=1 blank=1 sel=1111", idx, blank, sel); end
        cyc(1'b0, 4'hF);
        total++; if (blank !== 1'b1 || sel !== 4'hF) begin bad++; $display("FAIL blank_third blank=%b sel=%b exp blank=1 sel=1111", blank, sel); end
        cyc(1'b0, 4'hF);
        total++; if (blank !== 1'b0 || sel !== 4'b1101) begin bad++; $display("FAIL blank_end blank=%b sel=%b exp blank=0 sel=1101", blank, sel); end
`else
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 4'hF);
            total++; if (idx !== 2'(k % 4) || blank !== 1'b0) begin bad++; $display("FAIL b2b k=%0d idx=%0d blank=%b exp idx=%0d blank=0", k, idx, blank, k % 4); end
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] mk;
        logic       e;
        do_reset();
        mk = 4'hF;
        for (int n = 0; n < 400; n++) begin
            if (n % 16 == 15) mk = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) != 0);
            cyc(e, mk);
            total++; if (idx !== 2'(m_idx)) begin bad++; $display("FAIL rand_idx n=%0d got=%0d exp=%0d", n, idx, m_idx); end
            total++; if (sel !== m_sel) begin bad++; $display("FAIL rand_sel n=%0d got=%b exp=%b", n, sel, m_sel); end
            total++; if (tick !== m_tick) begin bad++; $display("FAIL rand_tick n=%0d got=%b exp=%b", n, tick, m_tick); end
            total++; if (blank !== (m_blank > 0)) begin bad++; $display("FAIL rand_blank n=%0d got=%b exp=%b", n, blank, (m_blank > 0)); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        en6   = 1'b0;
        mask  = 4'hF;
        mask6 = 6'h3F;
        model_reset();
        test_reset();
        test_full_scan();
        test_six_digit();
        test_sparse_mask();
        test_zero_mask();
        test_mask_current();
        test_async_reset();
        test_blank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
